// File: rtl/emailbox_reader.sv
// Hardware drain engine for the emailbox FIFO: wins the mi bus on mailbox_irq,
// pops one 64-bit entry with a MAILBOXLO read and offers it on a valid/ready port.

module emailbox_reader #(
    parameter int unsigned     RFAW        = 6,
    parameter int unsigned     RD_LAT      = 1,
    parameter int unsigned     SETTLE      = 4,
    parameter logic [RFAW-1:0] E_MAILBOXLO = RFAW'(9)
) (
    input  logic             rd_clk,
    input  logic             nreset,
    input  logic             enable,
    input  logic             mailbox_irq,
    output logic             mi_req,
    input  logic             mi_gnt,
    output logic             mi_en,
    output logic             mi_we,
    output logic [RFAW+1:0]  mi_addr,
    input  logic [63:0]      mi_din,
    output logic             msg_valid,
    output logic [63:0]      msg_data,
    input  logic             msg_ready,
    output logic [15:0]      msg_count,
    output logic             busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SETTLE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               capture;
    logic               handshake;

    assign handshake = msg_valid & msg_ready;

    // State and shared latency/settle counter
    always_ff @(posedge rd_clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; mi_en is a same-cycle response to the grant
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mi_en     = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                // Only start when the output slot is free or draining this cycle
                if (enable && mailbox_irq && (!msg_valid || msg_ready)) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mi_gnt) begin
                    mi_en     = 1'b1;
                    cnt_nxt   = CNT_W'(RD_LAT);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    cnt_nxt   = CNT_W'(SETTLE);
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // irq is stale here until the FIFO empty flag has resynchronised
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign mi_req  = (state == S_REQ);
    assign busy    = (state != S_IDLE);
    assign mi_we   = 1'b0;
    assign mi_addr = mi_en ? {E_MAILBOXLO, 2'b00} : '0;

    // Single-entry output register and delivered-message counter
    always_ff @(posedge rd_clk or negedge nreset) begin
        if (!nreset) begin
            msg_valid <= 1'b0;
            msg_data  <= '0;
            msg_count <= '0;
        end else begin
            if (capture) begin
                msg_valid <= 1'b1;
                msg_data  <= mi_din;
            end else if (handshake) begin
                msg_valid <= 1'b0;
            end
            if (handshake) begin
                msg_count <= msg_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/emailbox_reader.md
# emailbox_reader

Hardware drain engine for the mailbox FIFO (emailbox). It replaces the software ISR: when the mailbox interrupt is high it wins the shared mi register bus, pops one 64-bit entry with an E_MAILBOXLO read and presents the entry on a valid/ready message port for a downstream consumer such as a DMA or command decoder. It sits directly downstream of emailbox on the rd_clk domain.

## Interface
- RFAW, 6, register address width; mi_addr is RFAW+2 bits.
- RD_LAT, 1, cycles from the mi_en read cycle to valid mi_din; legal range 1-7.
- SETTLE, 4, idle cycles after each pop before mailbox_irq is trusted again; covers the async-FIFO empty-flag sync delay; legal range 1-15.
- rd_clk  in  1  clock (same clock as the emailbox read port).
- nreset  in  1  asynchronous active-low reset.
- enable  in  1  drain enable, level.
- mailbox_irq  in  1  level interrupt from emailbox.
- mi_req  out  1  request for the shared mi bus.
- mi_gnt  in  1  bus grant; valid only while mi_req=1.
- mi_en  out  1  register access strobe, one-cycle pulse.
- mi_we  out  1  always 0.
- mi_addr  out  RFAW+2  {E_MAILBOXLO, 2'b00} whenever mi_en=1, else 0.
- mi_din  in  64  read data from emailbox mi_dout.
- msg_valid  out  1  message available.
- msg_data  out  64  popped entry; [31:0]=data, [63:32]=srcaddr.
- msg_ready  in  1  consumer accept.
- msg_count  out  16  messages delivered (valid&ready handshakes), wraps.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, SETTLE. Encoding is free.
- IDLE: go to REQ when enable=1, mailbox_irq=1, and the output register is empty or is handshaking this cycle (msg_valid & msg_ready).
- REQ: mi_req=1. In any cycle with mi_gnt=1, drive mi_en=1 combinationally with the LO address, load the latency counter with RD_LAT, and go to WAIT. mi_req stays high until the grant cycle. mi_req drops in the cycle after the grant.
- WAIT: decrement the counter each cycle. In the cycle where the count would reach 0, sample mi_din into msg_data, set msg_valid and go to SETTLE.
- SETTLE: count SETTLE cycles, then go to IDLE. mailbox_irq is ignored during SETTLE.
- Output register: a single entry.
  - msg_valid stays high and msg_data holds stable until msg_ready=1.
  - A capture and a handshake in the same cycle leave msg_valid=1 with the new data.
  - The IDLE gate guarantees a capture never overwrites an unaccepted entry.
- msg_count increments by 1 on each valid&ready cycle and wraps from 0xFFFF to 0x0000.
- enable=0 is sampled only in IDLE. A transaction in progress always completes through SETTLE. This ensures an entry popped from the FIFO is never dropped.
- A read that has been issued cannot be cancelled except by reset.

## Timing
- Reset values (asynchronous): state=IDLE, mi_req=0, mi_en=0, mi_we=0, mi_addr=0, msg_valid=0, msg_data=0, msg_count=0, busy=0.
- Latency with mi_gnt held high:
  - irq rising edge seen in IDLE at cycle 0.
  - REQ with mi_en at cycle 1.
  - mi_din sampled at cycle 1+RD_LAT.
  - msg_valid=1 at cycle 2+RD_LAT.
- Throughput: with ready=1 and gnt=1, one message every 2+RD_LAT+SETTLE cycles; default 7.
- Grant delayed N cycles: all subsequent events shift by N. mi_en never asserts without mi_gnt.
- Reset asserted mid-WAIT: the popped entry is lost, which is accepted. All outputs return to reset values immediately. No mi_en is issued until reset is released and irq is seen again.
- mailbox_irq falling during REQ: the read still completes. emailbox's mi_dout returns gated data; an empty pop is the system's responsibility, same as software.

## Test plan
- Single message: write 0x11112222 from src 0xAAAA0000, enable=1, gnt=1, ready=1, defaults → exactly one mi_en pulse with mi_addr={E_MAILBOXLO,00}. msg_valid rises 3 cycles after irq, msg_data=0xAAAA0000_11112222, msg_count=1.
- Backpressure: queue 3 messages, hold ready=0 for 50 cycles → exactly one mi_en, msg_data stable. Release ready → remaining two are delivered in order, msg_count=3, FIFO empty, irq low.
- Grant delay: gnt low for 10 cycles → mi_req held 11 cycles, one mi_en on the grant cycle, data correct.
- Enable off: enable=0 with irq high → no mi_req for 100 cycles, busy=0. Drop enable during WAIT → the current message is delivered, then the block idles.
- Reset mid-WAIT with RD_LAT=3 → outputs zero the same cycle, msg_valid stays 0 after release until the next irq.
- Counter wrap: force 65536 handshakes → msg_count returns to 0x0000, no spurious mi_en.
